// File: rtl/ifm_window_buf.sv
// Sliding KxK window generator for a raster-order pixel stream.
// K-1 line buffers hold the previous rows; the window register shifts one column per accepted pixel.
module ifm_window_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned MAX_W  = 32,
  parameter int unsigned DIM_W  = $clog2(MAX_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    start,
  input  logic [DIM_W-1:0]        cfg_width,
  input  logic [DIM_W-1:0]        cfg_height,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    win_valid,
  output logic [K*K*DATA_W-1:0]   win_data,
  output logic [DIM_W-1:0]        win_row,
  output logic [DIM_W-1:0]        win_col,
  output logic                    frame_done,
  output logic                    cfg_err
);

  localparam int unsigned WIN_W = K * K * DATA_W;
  localparam int unsigned LB_N  = K - 1;
  localparam int unsigned AW    = $clog2(MAX_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   width_q, width_d;
  logic [DIM_W-1:0]   height_q, height_d;
  logic [DIM_W-1:0]   row_q, row_d;
  logic [DIM_W-1:0]   col_q, col_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               win_valid_q, win_valid_d;
  logic [WIN_W-1:0]   win_data_q, win_data_d;
  logic [DIM_W-1:0]   win_row_q, win_row_d;
  logic [DIM_W-1:0]   win_col_q, win_col_d;
  logic               frame_done_q, frame_done_d;
  logic               cfg_err_q, cfg_err_d;

  logic [DATA_W-1:0]  lb_q  [LB_N][MAX_W];
  logic [DATA_W-1:0]  lb_rd [LB_N];
  logic [DATA_W-1:0]  lb_wr [LB_N];
  logic [WIN_W-1:0]   win_shift;
  logic [AW-1:0]      col_idx;
  logic               accept;
  logic               qualify;
  logic               cfg_ok;

  assign in_ready   = (state_q == ST_RUN) && !stall;
  assign accept     = in_valid && in_ready;
  assign col_idx    = AW'(col_q);
  assign qualify    = accept && (row_q >= DIM_W'(K - 1)) && (col_q >= DIM_W'(K - 1));
  assign cfg_ok     = (cfg_width  >= DIM_W'(K)) && (cfg_width  <= DIM_W'(MAX_W)) &&
                      (cfg_height >= DIM_W'(K)) && (cfg_height <= DIM_W'(MAX_W));

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

  // Line-buffer read at the current column and the value chain written back (each row moves up one buffer).
  always_comb begin
    for (int unsigned j = 0; j < LB_N; j++) begin
      lb_rd[j] = lb_q[j][col_idx];
      lb_wr[j] = in_data;
    end
    for (int unsigned j = 0; j + 1 < LB_N; j++) begin
      lb_wr[j] = lb_rd[j + 1];
    end
  end

  // Window shifted left by one column with the fresh column (buffered rows + incoming pixel) on the right.
  always_comb begin
    win_shift = win_q;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c + 1 < K; c++) begin
        win_shift[(r*K + c)*DATA_W +: DATA_W] = win_q[(r*K + c + 1)*DATA_W +: DATA_W];
      end
    end
    for (int unsigned r = 0; r < LB_N; r++) begin
      win_shift[(r*K + K - 1)*DATA_W +: DATA_W] = lb_rd[r];
    end
    win_shift[(K*K - 1)*DATA_W +: DATA_W] = in_data;
  end

  // Next-state and output logic for the frame FSM and counters.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    row_d        = row_q;
    col_d        = col_q;
    win_d        = accept ? win_shift : win_q;
    win_valid_d  = qualify;
    win_data_d   = qualify ? win_shift : win_data_q;
    win_row_d    = qualify ? row_q : win_row_q;
    win_col_d    = qualify ? col_q : win_col_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            width_d  = cfg_width;
            height_d = cfg_height;
            row_d    = '0;
            col_d    = '0;
            state_d  = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (col_q == width_q - DIM_W'(1)) begin
            col_d = '0;
            if (row_q == height_q - DIM_W'(1)) begin
              row_d        = '0;
              state_d      = ST_DONE;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + DIM_W'(1);
            end
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control, window and output registers; everything holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else if (!stall) begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      win_data_q   <= win_data_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Line-buffer storage; contents are always rewritten before they reach a valid window, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned j = 0; j < LB_N; j++) begin
        lb_q[j][col_idx] <= lb_wr[j];
      end
    end
  end

endmodule

// File: tb/tb_ifm_window_buf.sv
// Bench for ifm_window_buf: image-level reference model, directed scenarios and randomized frames.
module tb_ifm_window_buf;

  localparam int DATA_W = 8;
  localparam int K      = 3;
  localparam int MAX_W  = 32;
  localparam int DIM_W  = 6;
  localparam int WIN_W  = K * K * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  cfg_width = '0;
  logic [DIM_W-1:0]  cfg_height = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              win_valid;
  logic [WIN_W-1:0]  win_data;
  logic [DIM_W-1:0]  win_row;
  logic [DIM_W-1:0]  win_col;
  logic              frame_done;
  logic              cfg_err;

  ifm_window_buf #(.DATA_W(DATA_W), .K(K), .MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .win_valid(win_valid), .win_data(win_data), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the image as accepted so far plus the next raster position.
  logic [DATA_W-1:0] img [MAX_W][MAX_W];
  bit                running = 1'b0;
  int                mr = 0, mc = 0, fw = 0, fh = 0;
  logic              e_valid = 1'b0, e_done = 1'b0, e_cerr = 1'b0;
  logic [WIN_W-1:0]  e_data = '0;
  logic [DIM_W-1:0]  e_row = '0, e_col = '0;

  // Observed window log, taken from DUT outputs on non-stalled edges.
  int                win_pix[$];
  int                win_cols[$];
  logic [WIN_W-1:0]  first_win;
  int                done_pix;

  function automatic logic [WIN_W-1:0] ref_window(int r, int c);
    logic [WIN_W-1:0] v;
    v = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        v[(i*K + j)*DATA_W +: DATA_W] = img[r-(K-1)+i][c-(K-1)+j];
    return v;
  endfunction

  task automatic clear_log();
    win_pix.delete();
    win_cols.delete();
    first_win = '0;
    done_pix  = -1;
  endtask

  // One clock of stimulus; model predicts the outputs after the edge.
  task automatic cycle(input bit v, input bit s, input logic [DATA_W-1:0] d);
    bit acc;
    bit exp_rdy;
    in_valid = v; stall = s; in_data = d; start = 1'b0;
    #1;
    exp_rdy = running && !s;
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready t=%0t got %b expected %b", $time, in_ready, exp_rdy);
    end
    acc = v && exp_rdy;
    if (!s) begin
      e_valid = 1'b0; e_done = 1'b0; e_cerr = 1'b0;
      if (acc) begin
        img[mr][mc] = d;
        if (mr >= K-1 && mc >= K-1) begin
          e_valid = 1'b1;
          e_data  = ref_window(mr, mc);
          e_row   = DIM_W'(mr);
          e_col   = DIM_W'(mc);
        end
        if (mc == fw-1) begin
          mc = 0;
          if (mr == fh-1) begin
            e_done = 1'b1; running = 1'b0; mr = 0;
          end else mr++;
        end else mc++;
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (win_valid !== e_valid) begin n_fail++; $display("FAIL win_valid t=%0t got %b expected %b", $time, win_valid, e_valid); end
    n_checks++;
    if (win_data !== e_data) begin n_fail++; $display("FAIL win_data t=%0t got %h expected %h", $time, win_data, e_data); end
    n_checks++;
    if (win_row !== e_row) begin n_fail++; $display("FAIL win_row t=%0t got %0d expected %0d", $time, win_row, e_row); end
    n_checks++;
    if (win_col !== e_col) begin n_fail++; $display("FAIL win_col t=%0t got %0d expected %0d", $time, win_col, e_col); end
    n_checks++;
    if (frame_done !== e_done) begin n_fail++; $display("FAIL frame_done t=%0t got %b expected %b", $time, frame_done, e_done); end
    n_checks++;
    if (cfg_err !== e_cerr) begin n_fail++; $display("FAIL cfg_err t=%0t got %b expected %b", $time, cfg_err, e_cerr); end
    if (!s && win_valid === 1'b1) begin
      if (win_pix.size() == 0) first_win = win_data;
      win_pix.push_back(int'(win_data[WIN_W-1 -: DATA_W]));
      win_cols.push_back(int'(win_col));
    end
    if (!s && frame_done === 1'b1) done_pix = int'(win_data[WIN_W-1 -: DATA_W]);
  endtask

  task automatic do_start(input int w, input int h);
    bit legal;
    start = 1'b1; cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
    in_valid = 1'b0; stall = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL start_in_ready got %b expected 0", in_ready); end
    legal = (w >= K) && (w <= MAX_W) && (h >= K) && (h <= MAX_W);
    e_valid = 1'b0; e_done = 1'b0; e_cerr = !legal;
    if (legal) begin running = 1'b1; mr = 0; mc = 0; fw = w; fh = h; end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (cfg_err !== e_cerr) begin n_fail++; $display("FAIL start_cfg_err w=%0d h=%0d got %b expected %b", w, h, cfg_err, e_cerr); end
    n_checks++;
    if (win_valid !== 1'b0) begin n_fail++; $display("FAIL start_win_valid got %b expected 0", win_valid); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL start_frame_done got %b expected 0", frame_done); end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, win_valid, frame_done, cfg_err} !== 4'b0) begin
      n_fail++; $display("FAIL async_reset_flags got %b expected 0000", {in_ready, win_valid, frame_done, cfg_err});
    end
    n_checks++;
    if ({win_data, win_row, win_col} !== '0) begin
      n_fail++; $display("FAIL async_reset_window got %h/%0d/%0d expected 0", win_data, win_row, win_col);
    end
    running = 1'b0; mr = 0; mc = 0;
    e_valid = 1'b0; e_done = 1'b0; e_cerr = 1'b0; e_data = '0; e_row = '0; e_col = '0;
    in_valid = 1'b0; stall = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic check_4x4_windows(input string tag);
    int exp_pix [4];
    exp_pix = '{11, 12, 15, 16};
    n_checks++;
    if (win_pix.size() !== 4) begin n_fail++; $display("FAIL %s_count got %0d expected 4", tag, win_pix.size()); end
    for (int i = 0; i < 4 && i < win_pix.size(); i++) begin
      n_checks++;
      if (win_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL %s_newest[%0d] got %0d expected %0d", tag, i, win_pix[i], exp_pix[i]); end
    end
    n_checks++;
    if (first_win !== 72'h0B0A09070605030201) begin n_fail++; $display("FAIL %s_first_window got %h expected 0b0a09070605030201", tag, first_win); end
    n_checks++;
    if (done_pix !== 16) begin n_fail++; $display("FAIL %s_done_window got %0d expected 16", tag, done_pix); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, win_valid, frame_done, cfg_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b expected 0000", {in_ready, win_valid, frame_done, cfg_err});
    end
    n_checks++;
    if ({win_data, win_row, win_col} !== '0) begin
      n_fail++; $display("FAIL reset_window got %h expected 0", win_data);
    end
    rst = 1'b1;
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic test_basic_frame();
    clear_log();
    do_start(4, 4);
    for (int p = 1; p <= 16; p++) cycle(1'b1, 1'b0, DATA_W'(p));
    cycle(1'b0, 1'b0, '0);
    check_4x4_windows("basic");
  endtask

  task automatic test_toggle_valid();
    clear_log();
    do_start(4, 4);
    for (int p = 1; p <= 16; p++) begin
      cycle(1'b1, 1'b0, DATA_W'(p));
      cycle(1'b0, 1'b0, DATA_W'(p + 100));
    end
    check_4x4_windows("toggle");
  endtask

  task automatic test_stall();
    clear_log();
    do_start(4, 4);
    for (int p = 1; p <= 12; p++) cycle(1'b1, 1'b0, DATA_W'(p));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 8'd13);
      n_checks++;
      if (win_valid !== 1'b1 || win_data[WIN_W-1 -: DATA_W] !== 8'd12) begin
        n_fail++; $display("FAIL stall_hold got valid=%b newest=%0d expected valid=1 newest=12", win_valid, win_data[WIN_W-1 -: DATA_W]);
      end
    end
    for (int p = 13; p <= 16; p++) cycle(1'b1, 1'b0, DATA_W'(p));
    cycle(1'b0, 1'b0, '0);
    check_4x4_windows("stall");
  endtask

  task automatic test_cfg_err();
    do_start(2, 4);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);
    do_start(MAX_W + 1, 4);
    cycle(1'b0, 1'b0, '0);
    do_start(4, 2);
    cycle(1'b0, 1'b0, '0);
    do_start(4, MAX_W + 1);
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_midframe();
    do_start(4, 4);
    for (int p = 1; p <= 7; p++) cycle(1'b1, 1'b0, DATA_W'(p));
    do_reset();
    cycle(1'b0, 1'b0, '0);
    test_basic_frame();
  endtask

  task automatic test_row_wrap();
    int exp_cols [3];
    exp_cols = '{2, 3, 4};
    clear_log();
    do_start(5, 3);
    for (int p = 1; p <= 15; p++) cycle(1'b1, 1'b0, DATA_W'(p));
    cycle(1'b0, 1'b0, '0);
    n_checks++;
    if (win_pix.size() !== 3) begin n_fail++; $display("FAIL wrap_count got %0d expected 3", win_pix.size()); end
    for (int i = 0; i < 3 && i < win_cols.size(); i++) begin
      n_checks++;
      if (win_cols[i] !== exp_cols[i]) begin n_fail++; $display("FAIL wrap_col[%0d] got %0d expected %0d", i, win_cols[i], exp_cols[i]); end
    end
    n_checks++;
    if (first_win !== 72'h0D0C0B080706030201) begin n_fail++; $display("FAIL wrap_first_window got %h expected 0d0c0b080706030201", first_win); end
    n_checks++;
    if (done_pix !== 15) begin n_fail++; $display("FAIL wrap_done_window got %0d expected 15", done_pix); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int w, h, guard;
      w = (f == 5) ? MAX_W : int'($urandom_range(3, 10));
      h = int'($urandom_range(3, 6));
      clear_log();
      do_start(w, h);
      guard = 0;
      while (running && guard < 4000) begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, DATA_W'($urandom));
        guard++;
      end
      n_checks++;
      if (guard >= 4000) begin n_fail++; $display("FAIL random_frame_timeout frame=%0d got %0d cycles expected fewer than 4000", f, guard); end
      cycle(1'b0, 1'b0, '0);
      n_checks++;
      if (win_pix.size() !== (w - K + 1) * (h - K + 1)) begin
        n_fail++; $display("FAIL random_window_count %0dx%0d got %0d expected %0d", w, h, win_pix.size(), (w - K + 1) * (h - K + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_toggle_valid();
    test_stall();
    test_cfg_err();
    test_reset_midframe();
    test_row_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
